ysyx_22041071_mem_arb: RTL and testbench
========================================

Name: ysyx_22041071_mem_arb

Overview:
Arbiter/sequencer that shares the single RAMHelper data port between the instruction-fetch requester (IF, read-only) and the load/store requester (LSU, read/write with byte mask). It sits between the IF and MEM pipeline stages and the RAMHelper instance. It accepts one request at a time, drives the memory port for one cycle and returns a registered response under valid/ready handshakes. LSU has priority, with a starvation guard for IF.

Parameters:
MEM_BASE, 64'h8000_0000, physical base address of RAM
MEM_SIZE, 64'h0800_0000, RAM size in bytes; legal range is [MEM_BASE, MEM_BASE+MEM_SIZE)
MAX_LS_STREAK, 4, consecutive LSU grants allowed while IF waits before IF is forced to win

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
if_req_valid  in  1  IF request valid
if_req_ready  out  1  IF request accepted this cycle
if_req_addr  in  64  fetch byte address
if_rsp_valid  out  1  IF response valid
if_rsp_ready  in  1  IF consumes response
if_rsp_rdata  out  64  aligned 64-bit word
if_rsp_err  out  1  address out of range
ls_req_valid  in  1  LSU request valid
ls_req_ready  out  1  LSU request accepted
ls_req_addr  in  64  byte address
ls_req_wen  in  1  1 = store, 0 = load
ls_req_wdata  in  64  store data, already lane-aligned
ls_req_wmask  in  64  bit mask
ls_rsp_valid  out  1  LSU response or store acknowledge
ls_rsp_ready  in  1  LSU consumes response
ls_rsp_rdata  out  64  load word (0 for stores)
ls_rsp_err  out  1  address out of range
mem_en  out  1  RAMHelper enable
mem_idx  out  64  word index = (addr - MEM_BASE) >> 3
mem_wen  out  1  RAMHelper write enable
mem_wdata  out  64  write data
mem_wmask  out  64  write mask
mem_rdata  in  64  RAMHelper read data, valid in the cycle mem_en is high

Behaviour:
- Clock and reset: single clock clk; reset is synchronous and active-high.
- Reset: state = IDLE; all rsp_valid = 0; rdata = 0; err = 0; mem_en = mem_wen = 0; mem_idx, mem_wdata, mem_wmask = 0; streak counter = 0. A reset that arrives mid-transaction drops the outstanding request with no response.
- States:
  - IDLE: req_ready is high for the granted side only. A handshake latches addr, wen, wdata, wmask and the owner, then moves to ISSUE.
  - ISSUE: one cycle. Drives mem_en = 1 and mem_idx from the latched address. mem_wen = latched wen AND in-range. Captures mem_rdata (loads) into the response register. Moves to RESP.
  - RESP: the owner's rsp_valid = 1. rdata and err stay stable until rsp_ready is seen. On the handshake the block returns to IDLE; no new request is accepted in that same cycle.
- Latency: request accepted at cycle T, memory accessed at T+1, rsp_valid at T+2. Best-case throughput is one transaction every 3 cycles.
- Grant rule in IDLE:
  - Only one side valid: that side wins.
  - Both valid: LSU wins unless streak == MAX_LS_STREAK, in which case IF wins.
- Streak counter:
  - Increments on an LSU grant while if_req_valid is high.
  - Clears on an IF grant, or on any grant while if_req_valid is low.
  - Saturates at MAX_LS_STREAK.
- Only one req_ready may be high in a cycle. Both are low outside IDLE.
- Out-of-range address (addr < MEM_BASE or addr >= MEM_BASE+MEM_SIZE):
  - ISSUE still occupies one cycle, but mem_en = 0 and mem_wen = 0.
  - The response carries err = 1 and rdata = 0.
- Stores: the response is an acknowledge with rdata = 0. The mask is passed through unchanged. wmask == 0 is legal and writes nothing.
- Index arithmetic: 64-bit unsigned subtraction followed by a logical right shift by 3. addr[2:0] are ignored; lane selection is the requester's job.
- Response registers hold their value when rsp_ready is low (backpressure); the block never overwrites them.

Decomposition:
- Shared define include gains:
  - the state encodings (IDLE = 2'd0, ISSUE = 2'd1, RESP = 2'd2)
  - the owner encoding (OWN_IF = 1'b0, OWN_LS = 1'b1)
  - the MEM_BASE and MEM_SIZE defaults
- One natural sub-module: ysyx_22041071_arb_pick. It is combinational grant selection plus the streak counter register, with inputs if_valid, ls_valid, idle, accept and outputs grant_if, grant_ls.

Test Plan:
- IF read 0x8000_0010, memory word 0x1122334455667788, if_rsp_ready = 1 → mem_idx = 2 at T+1; if_rsp_valid at T+2 with rdata 0x1122334455667788, err 0.
- LSU store addr 0x8000_0008, wmask 0xFF00, wdata 0xAB00 → mem_wen = 1 and mem_idx = 1 for exactly one cycle; ack with rdata 0. A following load of the same address returns the byte 0xAB in lane 1.
- IF and LSU held valid continuously (MAX_LS_STREAK = 4) → grant order LS, LS, LS, LS, IF, LS, LS, LS, LS, IF.
- ls_rsp_ready held low for 5 cycles → ls_rsp_valid and rdata stable; both req_ready stay 0; a pending IF request is granted in the cycle after the LSU handshake completes.
- Load at 0x7FFF_FFF8 and at MEM_BASE+MEM_SIZE → mem_en stays 0; rsp err = 1, rdata = 0. Store to the same addresses → mem_wen never asserted.
- Reset asserted during ISSUE → next cycle state IDLE, no rsp_valid, mem_wen = 0; a new IF request is accepted right after reset deasserts.

Source files
------------

// File: rtl/ysyx_22041071_mem_arb_pkg.sv
// Shared types and defaults for the RAMHelper port arbiter between IF and LSU.
package ysyx_22041071_mem_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_RESP  = 2'd2
  } arb_state_e;

  typedef enum logic {
    OWN_IF = 1'b0,
    OWN_LS = 1'b1
  } owner_e;

  localparam logic [63:0] MEM_BASE_DFLT      = 64'h8000_0000;
  localparam logic [63:0] MEM_SIZE_DFLT      = 64'h0800_0000;
  localparam int          MAX_LS_STREAK_DFLT = 4;

  typedef struct packed {
    owner_e      owner;
    logic [63:0] addr;
    logic        wen;
    logic [63:0] wdata;
    logic [63:0] wmask;
  } arb_req_t;

  // The second term is written as a difference so base+size never has to be formed.
  function automatic logic addr_in_range(input logic [63:0] addr,
                                         input logic [63:0] base,
                                         input logic [63:0] size);
    return (addr >= base) && ((addr - base) < size);
  endfunction

  function automatic logic [63:0] word_index(input logic [63:0] addr,
                                             input logic [63:0] base);
    return (addr - base) >> 3;
  endfunction

endpackage

// File: rtl/ysyx_22041071_arb_pick.sv
// Grant selection between IF and LSU, with the LSU-streak counter that
// forces an IF grant once the LSU has won MAX_LS_STREAK times in a row.
module ysyx_22041071_arb_pick
  import ysyx_22041071_mem_arb_pkg::*;
#(
  parameter int MAX_LS_STREAK = MAX_LS_STREAK_DFLT
) (
  input  logic clk,
  input  logic reset,
  input  logic if_valid,
  input  logic ls_valid,
  input  logic idle,
  input  logic accept,
  output logic grant_if,
  output logic grant_ls
);

  localparam int SW = (MAX_LS_STREAK > 0) ? $clog2(MAX_LS_STREAK + 1) : 1;
  localparam logic [SW-1:0] STREAK_MAX = SW'(MAX_LS_STREAK);

  logic [SW-1:0] streak_q, streak_d;
  logic          if_forced;

  assign if_forced = if_valid && (streak_q == STREAK_MAX);
  assign grant_ls  = idle && ls_valid && !if_forced;
  assign grant_if  = idle && if_valid && !grant_ls;

  always_comb begin
    streak_d = streak_q;
    if (accept) begin
      if (grant_ls && if_valid) begin
        streak_d = (streak_q == STREAK_MAX) ? streak_q : streak_q + SW'(1);
      end else begin
        streak_d = '0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      streak_q <= '0;
    end else begin
      streak_q <= streak_d;
    end
  end

endmodule

// File: rtl/ysyx_22041071_mem_arb.sv
// Shares the single RAMHelper port between IF (read-only) and LSU (read/write),
// one transaction at a time: accept, one memory cycle, registered response.
//
// state    | meaning
// ST_IDLE  | req_ready offered to the granted side; handshake latches the request
// ST_ISSUE | memory port driven for one cycle; response register captured
// ST_RESP  | owner's rsp_valid high until its rsp_ready
module ysyx_22041071_mem_arb
  import ysyx_22041071_mem_arb_pkg::*;
#(
  parameter logic [63:0] MEM_BASE      = MEM_BASE_DFLT,
  parameter logic [63:0] MEM_SIZE      = MEM_SIZE_DFLT,
  parameter int          MAX_LS_STREAK = MAX_LS_STREAK_DFLT
) (
  input  logic        clk,
  input  logic        reset,

  input  logic        if_req_valid,
  output logic        if_req_ready,
  input  logic [63:0] if_req_addr,
  output logic        if_rsp_valid,
  input  logic        if_rsp_ready,
  output logic [63:0] if_rsp_rdata,
  output logic        if_rsp_err,

  input  logic        ls_req_valid,
  output logic        ls_req_ready,
  input  logic [63:0] ls_req_addr,
  input  logic        ls_req_wen,
  input  logic [63:0] ls_req_wdata,
  input  logic [63:0] ls_req_wmask,
  output logic        ls_rsp_valid,
  input  logic        ls_rsp_ready,
  output logic [63:0] ls_rsp_rdata,
  output logic        ls_rsp_err,

  output logic        mem_en,
  output logic [63:0] mem_idx,
  output logic        mem_wen,
  output logic [63:0] mem_wdata,
  output logic [63:0] mem_wmask,
  input  logic [63:0] mem_rdata
);

  arb_state_e  state_q, state_d;
  arb_req_t    req_q, req_d;
  logic [63:0] rdata_q, rdata_d;
  logic        err_q, err_d;

  logic        idle, accept, in_range, rsp_hs;
  logic        grant_if, grant_ls;

  assign idle     = (state_q == ST_IDLE);
  assign accept   = idle && (if_req_valid || ls_req_valid);
  assign in_range = addr_in_range(req_q.addr, MEM_BASE, MEM_SIZE);
  assign rsp_hs   = (state_q == ST_RESP) &&
                    ((req_q.owner == OWN_LS) ? ls_rsp_ready : if_rsp_ready);

  ysyx_22041071_arb_pick #(
    .MAX_LS_STREAK (MAX_LS_STREAK)
  ) u_pick (
    .clk      (clk),
    .reset    (reset),
    .if_valid (if_req_valid),
    .ls_valid (ls_req_valid),
    .idle     (idle),
    .accept   (accept),
    .grant_if (grant_if),
    .grant_ls (grant_ls)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (accept) state_d = ST_ISSUE;
      ST_ISSUE: state_d = ST_RESP;
      ST_RESP:  if (rsp_hs) state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    if_req_ready = 1'b0;
    ls_req_ready = 1'b0;
    if_rsp_valid = 1'b0;
    ls_rsp_valid = 1'b0;
    mem_en       = 1'b0;
    mem_wen      = 1'b0;
    mem_idx      = '0;
    mem_wdata    = '0;
    mem_wmask    = '0;
    case (state_q)
      ST_IDLE: begin
        if_req_ready = grant_if;
        ls_req_ready = grant_ls;
      end
      ST_ISSUE: begin
        mem_en    = in_range;
        mem_wen   = in_range && req_q.wen;
        mem_idx   = word_index(req_q.addr, MEM_BASE);
        mem_wdata = req_q.wdata;
        mem_wmask = req_q.wmask;
      end
      ST_RESP: begin
        if_rsp_valid = (req_q.owner == OWN_IF);
        ls_rsp_valid = (req_q.owner == OWN_LS);
      end
      default: ;
    endcase
  end

  // Response register is written only in ISSUE, so it holds through backpressure.
  always_comb begin
    req_d   = req_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    if (accept) begin
      req_d.owner = grant_ls ? OWN_LS : OWN_IF;
      req_d.addr  = grant_ls ? ls_req_addr : if_req_addr;
      req_d.wen   = grant_ls && ls_req_wen;
      req_d.wdata = grant_ls ? ls_req_wdata : '0;
      req_d.wmask = grant_ls ? ls_req_wmask : '0;
    end
    if (state_q == ST_ISSUE) begin
      rdata_d = (in_range && !req_q.wen) ? mem_rdata : '0;
      err_d   = !in_range;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      req_q   <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      req_q   <= req_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  assign if_rsp_rdata = rdata_q;
  assign ls_rsp_rdata = rdata_q;
  assign if_rsp_err   = err_q;
  assign ls_rsp_err   = err_q;

endmodule

// File: tb/tb_ysyx_22041071_mem_arb.sv
// Bench for the IF/LSU memory arbiter: directed scenarios plus random traffic
// checked against a transaction-level model with its own memory image.
module tb_ysyx_22041071_mem_arb;

  localparam logic [63:0] MB   = 64'h8000_0000;
  localparam logic [63:0] MS   = 64'h0800_0000;
  localparam int          MAXS = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        if_req_valid = 1'b0, if_req_ready;
  logic [63:0] if_req_addr = '0;
  logic        if_rsp_valid, if_rsp_ready = 1'b1, if_rsp_err;
  logic [63:0] if_rsp_rdata;
  logic        ls_req_valid = 1'b0, ls_req_ready;
  logic [63:0] ls_req_addr = '0, ls_req_wdata = '0, ls_req_wmask = '0;
  logic        ls_req_wen = 1'b0;
  logic        ls_rsp_valid, ls_rsp_ready = 1'b1, ls_rsp_err;
  logic [63:0] ls_rsp_rdata;
  logic        mem_en, mem_wen;
  logic [63:0] mem_idx, mem_wdata, mem_wmask, mem_rdata;

  logic [63:0] ram [256];
  logic [63:0] mdl [256];

  int total = 0;
  int bad   = 0;

  int          phase  = 0;
  int          streak = 0;
  logic        acc_if = 1'b0, acc_ls = 1'b0;
  logic        t_owner, t_wen, t_in, e_err, obs_err;
  logic [63:0] t_addr, t_wdata, t_wmask, e_rdata, obs_rdata;
  int          en_cycles = 0, wen_cycles = 0;

  always #5 clk = ~clk;

  assign mem_rdata = ram[mem_idx[7:0]];

  ysyx_22041071_mem_arb dut (
    .clk          (clk),
    .reset        (reset),
    .if_req_valid (if_req_valid),
    .if_req_ready (if_req_ready),
    .if_req_addr  (if_req_addr),
    .if_rsp_valid (if_rsp_valid),
    .if_rsp_ready (if_rsp_ready),
    .if_rsp_rdata (if_rsp_rdata),
    .if_rsp_err   (if_rsp_err),
    .ls_req_valid (ls_req_valid),
    .ls_req_ready (ls_req_ready),
    .ls_req_addr  (ls_req_addr),
    .ls_req_wen   (ls_req_wen),
    .ls_req_wdata (ls_req_wdata),
    .ls_req_wmask (ls_req_wmask),
    .ls_rsp_valid (ls_rsp_valid),
    .ls_rsp_ready (ls_rsp_ready),
    .ls_rsp_rdata (ls_rsp_rdata),
    .ls_rsp_err   (ls_rsp_err),
    .mem_en       (mem_en),
    .mem_idx      (mem_idx),
    .mem_wen      (mem_wen),
    .mem_wdata    (mem_wdata),
    .mem_wmask    (mem_wmask),
    .mem_rdata    (mem_rdata)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [63:0] merge(input logic [63:0] old, input logic [63:0] wd,
                                        input logic [63:0] wm);
    return (old & ~wm) | (wd & wm);
  endfunction

  // One clock: check what the DUT shows this cycle, advance the model, then
  // return 1ns after the next rising edge so the caller can drive inputs.
  task automatic tick();
    logic        eg_if, eg_ls;
    logic [63:0] widx;
    @(negedge clk);
    acc_if = 1'b0;
    acc_ls = 1'b0;
    if (mem_en) en_cycles++;
    if (mem_en && mem_wen) wen_cycles++;
    if (phase == 0) begin
      eg_ls = ls_req_valid && !(if_req_valid && streak == MAXS);
      eg_if = if_req_valid && !eg_ls;
      chk("idle_if_ready", if_req_ready, eg_if);
      chk("idle_ls_ready", ls_req_ready, eg_ls);
      chk("idle_mem", {mem_en, mem_wen}, 0);
      chk("idle_rsp", {if_rsp_valid, ls_rsp_valid}, 0);
      if (!reset && (eg_if || eg_ls)) begin
        t_owner = eg_ls;
        t_addr  = eg_ls ? ls_req_addr : if_req_addr;
        t_wen   = eg_ls && ls_req_wen;
        t_wdata = ls_req_wdata;
        t_wmask = ls_req_wmask;
        if (eg_ls && if_req_valid) streak = (streak < MAXS) ? streak + 1 : MAXS;
        else streak = 0;
        acc_if = eg_if;
        acc_ls = eg_ls;
        phase  = 1;
      end
    end else if (phase == 1) begin
      t_in = (t_addr >= MB) && (t_addr < MB + MS);
      widx = (t_addr - MB) >> 3;
      chk("iss_en", mem_en, t_in);
      chk("iss_wen", mem_wen, t_in && t_wen);
      if (t_in) begin
        chk("iss_idx", mem_idx, widx);
        if (t_wen) begin
          chk("iss_wdata", mem_wdata, t_wdata);
          chk("iss_wmask", mem_wmask, t_wmask);
        end
      end
      chk("iss_ready", {if_req_ready, ls_req_ready}, 0);
      chk("iss_rsp", {if_rsp_valid, ls_rsp_valid}, 0);
      if (mem_en && mem_wen) ram[mem_idx[7:0]] = merge(ram[mem_idx[7:0]], mem_wdata, mem_wmask);
      e_err = !t_in;
      if (!t_in || t_wen) e_rdata = '0;
      else e_rdata = mdl[widx[7:0]];
      if (t_in && t_wen) mdl[widx[7:0]] = merge(mdl[widx[7:0]], t_wdata, t_wmask);
      phase = 2;
    end else begin
      chk("rsp_if_valid", if_rsp_valid, t_owner == 1'b0);
      chk("rsp_ls_valid", ls_rsp_valid, t_owner == 1'b1);
      obs_rdata = t_owner ? ls_rsp_rdata : if_rsp_rdata;
      obs_err   = t_owner ? ls_rsp_err : if_rsp_err;
      chk("rsp_rdata", obs_rdata, e_rdata);
      chk("rsp_err", obs_err, e_err);
      chk("rsp_ready", {if_req_ready, ls_req_ready}, 0);
      chk("rsp_mem_en", mem_en, 0);
      if (t_owner ? ls_rsp_ready : if_rsp_ready) phase = 0;
    end
    if (reset) begin
      phase  = 0;
      streak = 0;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    if_req_valid = 1'b0;
    ls_req_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    chk("rst_rsp_valid", {if_rsp_valid, ls_rsp_valid}, 0);
    chk("rst_if_rdata", if_rsp_rdata, 0);
    chk("rst_ls_rdata", ls_rsp_rdata, 0);
    chk("rst_err", {if_rsp_err, ls_rsp_err}, 0);
    chk("rst_mem_ctl", {mem_en, mem_wen}, 0);
    chk("rst_mem_bus", mem_idx | mem_wdata | mem_wmask, 0);
    chk("rst_ready", {if_req_ready, ls_req_ready}, 0);
    phase  = 0;
    streak = 0;
    acc_if = 1'b0;
    acc_ls = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    int budget;
    if_req_valid = 1'b0;
    ls_req_valid = 1'b0;
    if_rsp_ready = 1'b1;
    ls_rsp_ready = 1'b1;
    budget = 20;
    while (phase != 0 && budget > 0) begin
      tick();
      budget--;
    end
    if (phase != 0) chk("drain_timeout", 1, 0);
  endtask

  task automatic run_one(input logic is_ls, input logic [63:0] addr, input logic wen,
                         input logic [63:0] wd, input logic [63:0] wm);
    int budget;
    if_rsp_ready = 1'b1;
    ls_rsp_ready = 1'b1;
    if (is_ls) begin
      ls_req_valid = 1'b1; ls_req_addr = addr; ls_req_wen = wen;
      ls_req_wdata = wd; ls_req_wmask = wm;
    end else begin
      if_req_valid = 1'b1; if_req_addr = addr;
    end
    budget = 20;
    do begin
      tick();
      budget--;
    end while (!(acc_if || acc_ls) && budget > 0);
    if (!(acc_if || acc_ls)) chk("accept_timeout", 1, 0);
    drain();
  endtask

  function automatic logic [63:0] rand_addr();
    logic [63:0] lo;
    lo = 64'($urandom_range(0, 7));
    case ($urandom_range(0, 9))
      0:       return MB - 64'd8;
      1:       return MB + MS;
      2:       return MB + MS - 64'd8 + lo;
      3:       return {$urandom, $urandom};
      default: return MB + (64'($urandom_range(0, 255)) << 3) + lo;
    endcase
  endfunction

  function automatic logic [63:0] rand_mask();
    logic [63:0] m;
    logic [7:0]  b;
    case ($urandom_range(0, 3))
      0: m = '0;
      1: m = '1;
      2: begin
        b = 8'($urandom);
        for (int i = 0; i < 8; i++) m[i*8 +: 8] = {8{b[i]}};
      end
      default: m = {$urandom, $urandom};
    endcase
    return m;
  endfunction

  initial begin
    logic        exp_order [10];
    logic [63:0] rd0;
    int          n, budget, en0, wen0;

    for (int i = 0; i < 256; i++) begin
      ram[i] = {$urandom, $urandom};
      mdl[i] = ram[i];
    end
    ram[2] = 64'h1122_3344_5566_7788;
    mdl[2] = ram[2];

    // IF fetch with the documented latency
    do_reset();
    if_req_valid = 1'b1; if_req_addr = 64'h8000_0010; if_rsp_ready = 1'b1;
    tick();
    chk("t1_accept", acc_if, 1);
    if_req_valid = 1'b0;
    tick();
    chk("t1_valid_t2", if_rsp_valid, 1);
    chk("t1_rdata", if_rsp_rdata, 64'h1122_3344_5566_7788);
    chk("t1_err", if_rsp_err, 0);
    drain();

    // Store one lane then read it back
    wen0 = wen_cycles;
    run_one(1'b1, 64'h8000_0008, 1'b1, 64'h0000_0000_0000_AB00, 64'h0000_0000_0000_FF00);
    chk("t2_wen_once", 64'(wen_cycles - wen0), 1);
    chk("t2_ack_rdata", obs_rdata, 0);
    run_one(1'b1, 64'h8000_0008, 1'b0, '0, '0);
    chk("t2_lane1", {56'd0, obs_rdata[15:8]}, 64'hAB);

    // Starvation guard: both requesters always valid
    do_reset();
    exp_order = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    if_req_valid = 1'b1; if_req_addr = MB + 64'h40;
    ls_req_valid = 1'b1; ls_req_addr = MB + 64'h80; ls_req_wen = 1'b0;
    n = 0;
    budget = 100;
    while (n < 10 && budget > 0) begin
      tick();
      budget--;
      if (acc_if || acc_ls) begin
        chk($sformatf("t3_grant%0d", n), acc_ls, exp_order[n]);
        n++;
        if (acc_if) if_req_addr = MB + (64'($urandom_range(0, 255)) << 3);
        if (acc_ls) ls_req_addr = MB + (64'($urandom_range(0, 255)) << 3);
      end
    end
    if (n < 10) chk("t3_timeout", 64'(n), 10);
    drain();

    // Backpressure on the LSU response with an IF request waiting
    do_reset();
    ls_req_valid = 1'b1; ls_req_addr = MB + 64'h20; ls_req_wen = 1'b0; ls_rsp_ready = 1'b0;
    tick();
    chk("t4_accept", acc_ls, 1);
    ls_req_valid = 1'b0;
    tick();
    if_req_valid = 1'b1; if_req_addr = MB + 64'h30; if_rsp_ready = 1'b1;
    rd0 = ls_rsp_rdata;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("t4_hold_valid", ls_rsp_valid, 1);
      chk("t4_hold_rdata", ls_rsp_rdata, rd0);
    end
    ls_rsp_ready = 1'b1;
    tick();
    tick();
    chk("t4_if_next", acc_if, 1);
    drain();

    // Out-of-range loads and stores never touch memory
    en0 = en_cycles;
    wen0 = wen_cycles;
    run_one(1'b1, 64'h7FFF_FFF8, 1'b0, '0, '0);
    chk("t5_err_lo", obs_err, 1);
    run_one(1'b1, MB + MS, 1'b0, '0, '0);
    chk("t5_err_hi", obs_err, 1);
    run_one(1'b1, 64'h7FFF_FFF8, 1'b1, '1, '1);
    run_one(1'b1, MB + MS, 1'b1, '1, '1);
    run_one(1'b0, MB + MS, 1'b0, '0, '0);
    chk("t5_if_rdata", obs_rdata, 0);
    chk("t5_no_en", 64'(en_cycles - en0), 0);
    chk("t5_no_wen", 64'(wen_cycles - wen0), 0);

    // Reset while the memory cycle is in progress
    if_req_valid = 1'b1; if_req_addr = MB + 64'h48;
    tick();
    chk("t6_accept", acc_if, 1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    if_req_addr = MB + 64'h50;
    tick();
    chk("t6_accept_after_rst", acc_if, 1);
    drain();

    // Random traffic
    acc_if = 1'b0;
    acc_ls = 1'b0;
    for (int c = 0; c < 1500; c++) begin
      if (acc_if) if_req_valid = 1'b0;
      if (!if_req_valid && $urandom_range(0, 2) == 0) begin
        if_req_valid = 1'b1;
        if_req_addr  = rand_addr();
      end
      if (acc_ls) ls_req_valid = 1'b0;
      if (!ls_req_valid && $urandom_range(0, 2) == 0) begin
        ls_req_valid = 1'b1;
        ls_req_addr  = rand_addr();
        ls_req_wen   = 1'($urandom_range(0, 1));
        ls_req_wdata = {$urandom, $urandom};
        ls_req_wmask = rand_mask();
      end
      if_rsp_ready = ($urandom_range(0, 3) != 0);
      ls_rsp_ready = ($urandom_range(0, 3) != 0);
      tick();
    end
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog expired");
  end

endmodule
